// File: rtl/trenc_filter_unit.sv
// trenc_filter_unit: trace-encoder instruction filter.
// Qualifies retired uops against address-range comparators, a privilege mask
// and (optionally) a context ID, and tracks IDLE/WAIT/TRACE state.
// Build option: define TRENC_FILTER_CTX_EN to enable context matching;
// without it the context ports are present but ignored.
//
// Handshake: uop_valid_i is a pure qualifier with no ready/backpressure; a uop
// is consumed in exactly the cycle uop_valid_i is high, and every output is a
// registered reflection of the uop seen one cycle earlier.
module trenc_filter_unit #(
  parameter int NUM_CMP = 2,
  parameter int IADDR_W = 39,
  parameter int CTX_W   = 4
) (
  input  logic                       trenc_clk_i,
  input  logic                       trenc_rst_i,
  input  logic                       trenc_start_i,
  input  logic                       uop_valid_i,
  input  logic [IADDR_W-1:0]         uop_iaddr_i,
  input  logic [1:0]                 uop_priv_i,
  input  logic [CTX_W-1:0]           uop_ctx_i,
  input  logic                       cfg_filter_en_i,
  input  logic [NUM_CMP-1:0]         cfg_cmp_en_i,
  input  logic [NUM_CMP*IADDR_W-1:0] cfg_cmp_lo_i,
  input  logic [NUM_CMP*IADDR_W-1:0] cfg_cmp_hi_i,
  input  logic [3:0]                 cfg_priv_mask_i,
  input  logic                       cfg_ctx_en_i,
  input  logic [CTX_W-1:0]           cfg_ctx_i,
  output logic                       trenc_qualified_o,
  output logic                       trenc_qualified_first_o,
  output logic [1:0]                 trenc_state_o,
  output logic [15:0]                trenc_drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TRACE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        qual_q, qual_d;
  logic        first_q, first_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [NUM_CMP-1:0] cmp_hit;
  logic               addr_ok;
  logic               priv_ok;
  logic               ctx_ok;
  logic               match;

  // Range comparators: half-open [lo, hi); an empty range (lo >= hi) never hits.
  for (genvar k = 0; k < NUM_CMP; k++) begin : g_cmp
    logic [IADDR_W-1:0] lo;
    logic [IADDR_W-1:0] hi;
    assign lo         = cfg_cmp_lo_i[k*IADDR_W +: IADDR_W];
    assign hi         = cfg_cmp_hi_i[k*IADDR_W +: IADDR_W];
    assign cmp_hit[k] = cfg_cmp_en_i[k] && (lo < hi) &&
                        (uop_iaddr_i >= lo) && (uop_iaddr_i < hi);
  end

  // With no comparator enabled the address filter is transparent.
  assign addr_ok = (cfg_cmp_en_i == '0) || (|cmp_hit);
  assign priv_ok = cfg_priv_mask_i[uop_priv_i];

`ifdef TRENC_FILTER_CTX_EN
  assign ctx_ok = !cfg_ctx_en_i || (uop_ctx_i == cfg_ctx_i);
`else
  logic unused_ctx;
  assign ctx_ok     = 1'b1;
  assign unused_ctx = ^{uop_ctx_i, cfg_ctx_en_i, cfg_ctx_i};
`endif

  assign match = uop_valid_i && (!cfg_filter_en_i || (addr_ok && priv_ok && ctx_ok));

  // Next-state: dropping start wins over everything; IDLE ignores uops.
  always_comb begin
    state_d    = state_q;
    qual_d     = 1'b0;
    first_d    = 1'b0;
    drop_cnt_d = drop_cnt_q;
    if (!trenc_start_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          drop_cnt_d = 16'd0;
        end
        ST_WAIT, ST_TRACE: begin
          if (match) begin
            qual_d  = 1'b1;
            first_d = (state_q == ST_WAIT);
            state_d = ST_TRACE;
          end else if (uop_valid_i) begin
            state_d = ST_WAIT;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; synchronous reset overrides start.
  always_ff @(posedge trenc_clk_i) begin
    if (trenc_rst_i) begin
      state_q    <= ST_IDLE;
      qual_q     <= 1'b0;
      first_q    <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      qual_q     <= qual_d;
      first_q    <= first_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign trenc_qualified_o       = qual_q;
  assign trenc_qualified_first_o = first_q;
  assign trenc_state_o           = state_q;
  assign trenc_drop_cnt_o        = drop_cnt_q;

endmodule

// File: doc/trenc_filter_unit.md
TRENC_FILTER_UNIT -- requirements
Module: trenc_filter_unit

Interface
REQ-001 Parameter NUM_CMP, default 2, number of address-range comparators, legal range 1..4.
REQ-002 Parameter IADDR_W, default 39, instruction address width.
REQ-003 Parameter CTX_W, default 4, context ID width.
REQ-004 trenc_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 trenc_rst_i  in  1  reset, synchronous, active-high.
REQ-006 trenc_start_i  in  1  trace enable; high means encoder is running.
REQ-007 uop_valid_i  in  1  a retired instruction is presented this cycle.
REQ-008 uop_iaddr_i  in  IADDR_W  instruction address.
REQ-009 uop_priv_i  in  2  privilege level of the instruction.
REQ-010 uop_ctx_i  in  CTX_W  context ID of the instruction.
REQ-011 cfg_filter_en_i  in  1  0 means every valid uop qualifies.
REQ-012 cfg_cmp_en_i  in  NUM_CMP  per-comparator enable.
REQ-013 cfg_cmp_lo_i / cfg_cmp_hi_i  in  NUM_CMP*IADDR_W each  range bounds; comparator k in slice [k*IADDR_W +: IADDR_W].
REQ-014 cfg_priv_mask_i  in  4  bit p set means privilege p is traced.
REQ-015 cfg_ctx_en_i  in  1  enable context match; cfg_ctx_i  in  CTX_W  context value.
REQ-016 trenc_qualified_o  out  1  registered: uop of previous cycle qualified.
REQ-017 trenc_qualified_first_o  out  1  registered: single-cycle pulse marking the first qualified uop after start or after a gap.
REQ-018 trenc_state_o  out  2  FSM state: 0 IDLE, 1 WAIT, 2 TRACE.
REQ-019 trenc_drop_cnt_o  out  16  count of valid uops rejected while started.

Function
REQ-020 Comparator k SHALL hit when cfg_cmp_en_i[k] and lo <= iaddr < hi, unsigned compare; lo >= hi never hits.
REQ-021 addr_ok SHALL be 1 when no comparator is enabled, else the OR of all hits.
REQ-022 priv_ok SHALL be cfg_priv_mask_i[uop_priv_i]; ctx_ok per Configuration.
REQ-023 match SHALL be uop_valid_i && (!cfg_filter_en_i || (addr_ok && priv_ok && ctx_ok)).
REQ-024 FSM IDLE -> WAIT when trenc_start_i=1; any state -> IDLE when trenc_start_i=0, taking priority over all other transitions.
REQ-025 WAIT -> TRACE on match; TRACE -> WAIT on a valid uop with match=0; no valid uop leaves state unchanged.
REQ-026 In WAIT or TRACE with trenc_start_i=1, trenc_qualified_o SHALL be match, registered, one-cycle latency.
REQ-027 trenc_qualified_first_o SHALL be 1 for exactly the cycle following a match taken in WAIT, else 0.
REQ-028 In IDLE, or when trenc_start_i=0 in the same cycle as a uop, the uop SHALL be ignored and both qualified outputs SHALL be 0 next cycle.
REQ-029 trenc_drop_cnt_o SHALL increment on valid && !match in WAIT/TRACE with start=1, saturate at 0xFFFF, and clear on IDLE -> WAIT.
REQ-030 cfg_* inputs are quasi-static; a change takes effect on the next uop with no pipeline flush.

Reset
REQ-031 With trenc_rst_i=1 at a clock edge: state IDLE, trenc_qualified_o=0, trenc_qualified_first_o=0, trenc_drop_cnt_o=0; reset overrides trenc_start_i.
REQ-032 Reset asserted mid-trace SHALL lose the trace; the next first qualified uop after start SHALL pulse trenc_qualified_first_o.

Configuration
REQ-033 Macro TRENC_FILTER_CTX_EN defined: ctx_ok = !cfg_ctx_en_i || (uop_ctx_i == cfg_ctx_i).
REQ-034 Macro TRENC_FILTER_CTX_EN undefined: ctx_ok is constant 1; uop_ctx_i, cfg_ctx_en_i and cfg_ctx_i remain ports and are ignored.

Verification
REQ-035 Reset, start=1, filter_en=0, valid uop at 0x100 -> next cycle qualified=1, first=1, state=TRACE; second uop -> qualified=1, first=0.
REQ-036 Cmp0 [0x1000,0x2000) enabled; uops at 0x0FFF, 0x1000, 0x1FFF, 0x2000 -> qualified 0,1,1,0; first pulses with 0x1000; drop_cnt=2.
REQ-037 Gap: qualified uop, rejected uop, qualified uop -> state TRACE, WAIT, TRACE; first pulses on first and third.
REQ-038 priv_mask=4'b0001, uops with priv 0 then 3 -> qualified 1 then 0; with TRENC_FILTER_CTX_EN, ctx_en=1, ctx=5, uop ctx 4 -> qualified=0.
REQ-039 Start dropped in the same cycle as a matching uop -> next cycle qualified=0, first=0, state=IDLE; 70000 rejects -> drop_cnt holds 0xFFFF.
REQ-040 Reset asserted during TRACE with start=1 -> outputs 0 and state IDLE; after release the first match pulses first=1 and drop_cnt restarts at 0.
